// File: rtl/daq_pkg.sv
// -----------------------------------------------------------------------------
// daq_pkg
// Shared constants for the DAQ-link frame unpacker: link and FIFO word widths
// and the legacy-compatible state encoding of the unpacker FSM.
// -----------------------------------------------------------------------------
package daq_pkg;

  localparam int DAQ_W  = 64;
  localparam int FIFO_W = 32;

  // Unpacker FSM states.
  // WAIT_HDR  : idle, outside a frame, waiting for a header word
  // WAIT_BODY : idle, inside a frame, waiting for data or trailer
  // HI        : presenting the high half of the buffered word
  // LO        : presenting the low half of the buffered word
  localparam logic [1:0] WAIT_HDR  = 2'd0;
  localparam logic [1:0] WAIT_BODY = 2'd1;
  localparam logic [1:0] HI        = 2'd2;
  localparam logic [1:0] LO        = 2'd3;

endpackage

// File: rtl/daq_frame_unpacker.sv
// -----------------------------------------------------------------------------
// daq_frame_unpacker
// Accepts 64-bit DAQ-link words tagged header/trailer, checks frame order and
// emits every accepted word as two 32-bit beats (bits 63:32 first, then 31:0).
// A frame is one header, any number of data words and one trailer; out_last
// marks the low beat of the trailer.
//
// Ports
//   clk, rst_n        single clock, synchronous active-low reset
//   in_data[63:0]     DAQ word, with in_header / in_trailer tags
//   in_valid/in_ready input handshake (in_ready decoded from state)
//   out_data[31:0]    FIFO-side beat, with out_last
//   out_valid/out_ready output handshake
//   frame_done        one-cycle pulse after the trailer low beat transfers
//   frame_words       word count (header+data+trailer) of last completed frame
//   err_seq           one-cycle pulse on any framing violation
// -----------------------------------------------------------------------------
module daq_frame_unpacker
  import daq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DAQ_W-1:0]  in_data,
  input  logic              in_header,
  input  logic              in_trailer,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FIFO_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_words,
  output logic              err_seq
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]        state_r,       state_s;
  logic [DAQ_W-1:0]  buf_r,         buf_s;
  logic [CNT_W-1:0]  cnt_r,         cnt_s;
  logic              is_trl_r,      is_trl_s;
  logic [FIFO_W-1:0] out_data_r,    out_data_s;
  logic              out_valid_r,   out_valid_s;
  logic              out_last_r,    out_last_s;
  logic              frame_done_r,  frame_done_s;
  logic [CNT_W-1:0]  frame_words_r, frame_words_s;
  logic              err_seq_r,     err_seq_s;
  logic              load_s;
  logic [CNT_W-1:0]  cnt_inc_s;

  // Input is only taken while no word is being split into beats.
  assign in_ready = (state_r == WAIT_HDR) || (state_r == WAIT_BODY);

  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign out_last    = out_last_r;
  assign frame_done  = frame_done_r;
  assign frame_words = frame_words_r;
  assign err_seq     = err_seq_r;

  // Saturating word-counter increment.
  always_comb begin
    if (cnt_r == CNT_MAX) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_ONE;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_s       = state_r;
    buf_s         = buf_r;
    cnt_s         = cnt_r;
    is_trl_s      = is_trl_r;
    out_data_s    = out_data_r;
    out_valid_s   = out_valid_r;
    out_last_s    = out_last_r;
    frame_done_s  = 1'b0;
    frame_words_s = frame_words_r;
    err_seq_s     = 1'b0;
    load_s        = 1'b0;

    case (state_r)
      WAIT_HDR: begin
        if (in_valid) begin
          if (in_header && !in_trailer) begin
            cnt_s    = CNT_ONE;
            is_trl_s = 1'b0;
            load_s   = 1'b1;
          end else begin
            // Data/trailer outside a frame, or a doubly tagged word: drop it.
            err_seq_s = 1'b1;
          end
        end else begin
          load_s = 1'b0;
        end
      end

      WAIT_BODY: begin
        if (in_valid) begin
          if (in_header && in_trailer) begin
            err_seq_s = 1'b1;
          end else if (in_header) begin
            // Header inside a frame restarts the frame; the old frame is
            // abandoned without a synthetic last beat.
            err_seq_s = 1'b1;
            cnt_s     = CNT_ONE;
            is_trl_s  = 1'b0;
            load_s    = 1'b1;
          end else begin
            cnt_s    = cnt_inc_s;
            is_trl_s = in_trailer;
            load_s   = 1'b1;
          end
        end else begin
          load_s = 1'b0;
        end
      end

      HI: begin
        if (out_ready) begin
          state_s    = LO;
          out_data_s = buf_r[FIFO_W-1:0];
          out_last_s = is_trl_r;
        end else begin
          state_s = HI;
        end
      end

      LO: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          out_last_s  = 1'b0;
          if (is_trl_r) begin
            state_s       = WAIT_HDR;
            frame_done_s  = 1'b1;
            frame_words_s = cnt_r;
            is_trl_s      = 1'b0;
          end else begin
            state_s = WAIT_BODY;
          end
        end else begin
          state_s = LO;
        end
      end

      default: begin
        state_s     = WAIT_HDR;
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
      end
    endcase

    // Common word-load path: buffer the word and present its high half.
    if (load_s) begin
      state_s     = HI;
      buf_s       = in_data;
      out_data_s  = in_data[DAQ_W-1:FIFO_W];
      out_valid_s = 1'b1;
      out_last_s  = 1'b0;
    end else begin
      buf_s = buf_s;
    end
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= WAIT_HDR;
      buf_r         <= {DAQ_W{1'b0}};
      cnt_r         <= CNT_ZERO;
      is_trl_r      <= 1'b0;
      out_data_r    <= {FIFO_W{1'b0}};
      out_valid_r   <= 1'b0;
      out_last_r    <= 1'b0;
      frame_done_r  <= 1'b0;
      frame_words_r <= CNT_ZERO;
      err_seq_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      buf_r         <= buf_s;
      cnt_r         <= cnt_s;
      is_trl_r      <= is_trl_s;
      out_data_r    <= out_data_s;
      out_valid_r   <= out_valid_s;
      out_last_r    <= out_last_s;
      frame_done_r  <= frame_done_s;
      frame_words_r <= frame_words_s;
      err_seq_r     <= err_seq_s;
    end
  end

endmodule
